// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch sequencer and imem.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: handshaked imem requests, output slot plus one-entry skid, redirect flush.
// Optional saturating perf counters are compiled in with `define FETCH_PERF_CNT_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_f,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_ctrl_if.master imem,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  pc_f,
  output logic [31:0]  pc_plus_4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  wait_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcf_q, pcf_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        busy, xfer, consume, drain, issue;
  logic [31:0] target;
  logic        unused_rpc_lsb;

  assign busy           = (state_q != S_IDLE);
  assign xfer           = busy && imem.imem_ready;
  assign consume        = out_valid_q && !stall_f;
  assign drain          = skid_valid_q && !stall_f;
  assign target         = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= '0;
      out_valid_q  <= 1'b0;
      instr_q      <= '0;
      pcf_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      out_valid_q  <= out_valid_d;
      instr_q      <= instr_d;
      pcf_q        <= pcf_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    out_valid_d  = out_valid_q;
    instr_d      = instr_q;
    pcf_d        = pcf_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    issue        = 1'b0;

    if (redirect_valid) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      // An outstanding request cannot be aborted: park the target and drop its response later.
      if (busy && !imem.imem_ready) begin
        pc_d    = target;
        state_d = S_DROP;
      end else begin
        addr_d  = target;
        pc_d    = target + 32'(PC_STEP);
        state_d = S_REQ;
      end
    end else begin
      if (consume) out_valid_d = 1'b0;
      if (drain) begin
        out_valid_d  = 1'b1;
        instr_d      = skid_instr_q;
        pcf_d        = skid_pc_q;
        skid_valid_d = 1'b0;
      end
      if (xfer && state_q == S_REQ) begin
        if (!drain && (!out_valid_q || consume)) begin
          out_valid_d = 1'b1;
          instr_d     = imem.imem_rdata;
          pcf_d       = addr_q;
        end else begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem.imem_rdata;
          skid_pc_d    = addr_q;
        end
      end
      // A new request may start only from idle or on a completing transfer, never while a word waits in skid.
      if (state_q == S_IDLE || xfer) begin
        issue = !skid_valid_d && !drain;
        if (!issue) state_d = S_IDLE;
      end
      if (issue) begin
        addr_d  = pc_q;
        pc_d    = pc_q + 32'(PC_STEP);
        state_d = S_REQ;
      end
    end
  end

  assign imem.imem_req  = busy;
  assign imem.imem_addr = addr_q;
  assign instr_valid    = out_valid_q;
  assign instr          = instr_q;
  assign pc_f           = pcf_q;
  assign pc_plus_4      = pcf_q + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, wait_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (out_valid_q && stall_f && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (busy && !imem.imem_ready && wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign wait_cycles  = wait_cnt_q;
`endif

endmodule
